sobel_stream: RTL and testbench

Streaming 3x3 Sobel edge detector, a parametrised successor to the counter-based sobel controller. It accepts one grayscale pixel per cycle in raster order, using a valid/ready handshake. Two on-chip line buffers plus a 3x3 window register replace the 9-pixel/3-pixel reload scheme. It emits one gradient magnitude per accepted interior pixel, with full backpressure support. It sits between the grayscale converter and the output frame writer.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_kernel.sv | 30 +++
 rtl/sobel_stream.sv | 121 ++++++++++++
 tb/tb_sobel_stream.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and default configuration for the streaming Sobel filter.
// Window pixels are fixed at DEF_PIXEL_WIDTH bits; instantiate sobel_stream with matching PIXEL_WIDTH.
package sobel_pkg;

  localparam int DEF_PIXEL_WIDTH     = 8;
  localparam int DEF_IMG_WIDTH       = 640;
  localparam int DEF_IMG_HEIGHT      = 480;
  localparam int DEF_SOBEL_THRESHOLD = 128;

  localparam int COL_BITS   = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_BITS   = $clog2(DEF_IMG_HEIGHT);
  localparam int GRAD_WIDTH = DEF_PIXEL_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} sobel_state_t;

  typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

  // p<row><col>; row 0 is the oldest line, col 0 the leftmost pixel
  typedef struct packed {
    pixel_t p00, p01, p02;
    pixel_t p10, p11, p12;
    pixel_t p20, p21, p22;
  } sobel_window_t;

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel: Gx/Gy, |Gx|+|Gy|, saturated to the pixel range.
module sobel_kernel
  import sobel_pkg::*;
(
  input  sobel_window_t win,
  output pixel_t        mag
);

  localparam int SW = DEF_PIXEL_WIDTH + 3;

  logic signed [SW-1:0]  gx, gy;
  logic        [SW-1:0]  ax, ay;
  logic [GRAD_WIDTH-1:0] sum;

  function automatic logic signed [SW-1:0] ext(input pixel_t p);
    return $signed({3'b000, p});
  endfunction

  assign gx = (ext(win.p02) + (ext(win.p12) <<< 1) + ext(win.p22))
            - (ext(win.p00) + (ext(win.p10) <<< 1) + ext(win.p20));
  assign gy = (ext(win.p20) + (ext(win.p21) <<< 1) + ext(win.p22))
            - (ext(win.p00) + (ext(win.p01) <<< 1) + ext(win.p02));

  // |G| fits SW bits unsigned: the most negative gradient is -4*max, well inside range
  assign ax  = gx[SW-1] ? -gx : gx;
  assign ay  = gy[SW-1] ? -gy : gy;
  assign sum = {1'b0, ax} + {1'b0, ay};
  assign mag = (|sum[GRAD_WIDTH-1:DEF_PIXEL_WIDTH]) ? '1 : sum[DEF_PIXEL_WIDTH-1:0];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with two line buffers and valid/ready on both sides.
// Define SOBEL_BINARIZE_EN to threshold the magnitude to 0 / full scale.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
  parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT,
  parameter int SOBEL_THRESHOLD = DEF_SOBEL_THRESHOLD
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   start_i,
  input  logic [PIXEL_WIDTH-1:0] in_px_gray_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [PIXEL_WIDTH-1:0] out_px_sobel_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   frame_done_o,
  output logic                   busy_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  sobel_state_t  state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  sobel_window_t win, win_nxt;
  pixel_t        lb0 [IMG_WIDTH];
  pixel_t        lb1 [IMG_WIDTH];
  pixel_t        mag, px_out;
  logic          accept, row_end;

  assign in_ready_o = ((state == FILL) || (state == STREAM)) && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign row_end    = (col == COL_LAST);

  // Kernel sees the window as it will be after this acceptance, giving 1-cycle latency
  always_comb begin
    win_nxt     = win;
    win_nxt.p00 = win.p01;
    win_nxt.p01 = win.p02;
    win_nxt.p02 = lb1[col];
    win_nxt.p10 = win.p11;
    win_nxt.p11 = win.p12;
    win_nxt.p12 = lb0[col];
    win_nxt.p20 = win.p21;
    win_nxt.p21 = win.p22;
    win_nxt.p22 = pixel_t'(in_px_gray_i);
  end

  sobel_kernel u_kernel (
    .win (win_nxt),
    .mag (mag)
  );

`ifdef SOBEL_BINARIZE_EN
  assign px_out = (mag < pixel_t'(SOBEL_THRESHOLD)) ? '0 : '1;
`else
  assign px_out = mag;
`endif

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pixel_t'(in_px_gray_i);
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      win            <= '0;
      out_px_sobel_o <= '0;
      out_valid_o    <= 1'b0;
      frame_done_o   <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;

      if (accept) begin
        win <= win_nxt;
        col <= row_end ? '0 : col + 1'b1;
        if (row_end) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        // Only interior centres: row >= 2 is implied by STREAM, col >= 2 checked here
        if ((state == STREAM) && (col >= CW'(2))) begin
          out_px_sobel_o <= PIXEL_WIDTH'(px_out);
          out_valid_o    <= 1'b1;
        end
      end

      case (state)
        IDLE: if (start_i) begin
          state  <= FILL;
          busy_o <= 1'b1;
          col    <= '0;
          row    <= '0;
        end
        FILL:   if (accept && row_end && (row == RW'(1))) state <= STREAM;
        STREAM: if (accept && row_end && (row == ROW_LAST)) state <= DRAIN;
        DRAIN: begin
          if (frame_done_o) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (!out_valid_o || out_ready_i) begin
            frame_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on a 5x5 frame; expected magnitudes come from a direct Sobel model.
module tb_sobel_stream;

  localparam int PW = 8;
  localparam int W  = 5;
  localparam int H  = 5;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] in_px = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] out_px;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          frame_done;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int out_cnt = 0;
  int done_cnt = 0;

  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] img [H][W];

  always #5 clk = ~clk;

  sobel_stream #(
    .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SOBEL_THRESHOLD(128)
  ) dut (
    .clk_i          (clk),
    .nreset_i       (nrst),
    .start_i        (start),
    .in_px_gray_i   (in_px),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_px_sobel_o (out_px),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .frame_done_o   (frame_done),
    .busy_o         (busy)
  );

  function automatic int px(input int r, input int c);
    return int'(img[r][c]);
  endfunction

  function automatic int sobel_ref(input int r, input int c);
    int gx, gy, m;
    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
`ifdef SOBEL_BINARIZE_EN
    m = (m < 128) ? 0 : 255;
`endif
    return m;
  endfunction

  // kind: 0 flat(val), 1 vertical edge, 2 ramp, 3 random
  task automatic load(input int kind, input int val, input bit push);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = PW'(val);
          1: img[r][c] = (c < 2) ? 8'd0 : 8'd255;
          2: img[r][c] = PW'(c * 10);
          default: img[r][c] = PW'($urandom_range(0, 255));
        endcase
    if (push)
      for (int r = 1; r < H-1; r++)
        for (int c = 1; c < W-1; c++)
          exp_q.push_back(PW'(sobel_ref(r, c)));
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input bit stall, input bit poke_start);
    out_cnt  = 0;
    done_cnt = 0;
    fork
      begin : drive
        logic acc;
        int   budget;
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++) begin
            in_px = img[r][c]; in_valid = 1'b1; budget = 0;
            do begin
              @(negedge clk); acc = in_ready;
              @(posedge clk); #1; budget++;
            end while (!acc && budget < 50);
            if (!acc) begin
              vectors++; miscompares++;
              $display("FAIL in_ready_timeout pixel (%0d,%0d) not accepted in %0d cycles", r, c, budget);
            end
          end
        in_valid = 1'b0;
      end
      begin : check
        logic          held_v = 1'b0;
        logic [PW-1:0] held_px = '0;
        logic [PW-1:0] e;
        int            tail = 0;
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (held_v) begin
            vectors++;
            if (out_valid !== 1'b1 || out_px !== held_px) begin
              miscompares++;
              $display("FAIL stall_hold got valid=%0b px=%0d want valid=1 px=%0d", out_valid, out_px, held_px);
            end
          end
          held_v  = out_valid && !out_ready;
          held_px = out_px;
          if (out_valid && out_ready) begin
            out_cnt++; vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL sb_extra got px=%0d want no output", out_px);
            end else begin
              e = exp_q.pop_front();
              if (out_px !== e) begin
                miscompares++;
                $display("FAIL sb_px output %0d got %0d want %0d", out_cnt, out_px, e);
              end
            end
          end
          vectors++;
          if (busy !== (done_cnt == 0)) begin
            miscompares++;
            $display("FAIL busy got %0b want %0b", busy, done_cnt == 0);
          end
          if (frame_done) done_cnt++;
          if (done_cnt > 0) begin
            tail++;
            if (tail > 3) break;
          end
        end
      end
      begin : ctrl
        if (stall) begin
          for (int k = 0; k < 200 && out_cnt < 1; k++) @(negedge clk);
          @(posedge clk); #1 out_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
              miscompares++;
              $display("FAIL stall_ready got in_ready=%0b out_valid=%0b want 0/1", in_ready, out_valid);
            end
          end
          @(posedge clk); #1 out_ready = 1'b1;
        end
        if (poke_start) begin
          for (int k = 0; k < 200 && out_cnt < 2; k++) @(negedge clk);
          @(posedge clk); #1 start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
      end
    join
    vectors += 3;
    if (out_cnt !== 9) begin
      miscompares++; $display("FAIL out_count got %0d want 9", out_cnt);
    end
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL sb_missing got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL frame_done_pulses got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    #23;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_px !== '0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values got rdy=%0b vld=%0b px=%0d done=%0b busy=%0b want all 0",
               in_ready, out_valid, out_px, frame_done, busy);
    end
    @(posedge clk); #1 nrst = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_flat();
    load(0, 100, 1'b1); do_start(); run_frame(1'b0, 1'b0);
  endtask

  task automatic test_vertical_edge();
    load(1, 0, 1'b1); do_start(); run_frame(1'b0, 1'b0);
  endtask

  task automatic test_ramp();
    load(2, 0, 1'b1); do_start(); run_frame(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    load(3, 0, 1'b1); do_start(); run_frame(1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic acc;
    load(3, 0, 1'b0); do_start();
    for (int i = 0; i < 2*W + 1; i++) begin
      in_px = img[i / W][i % W]; in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        if (acc) break;
      end
    end
    in_valid = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_px !== '0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset got rdy=%0b vld=%0b px=%0d done=%0b busy=%0b want all 0",
               in_ready, out_valid, out_px, frame_done, busy);
    end
    @(posedge clk); #1 nrst = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset got busy=%0b in_ready=%0b want 0/0", busy, in_ready);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    load(0, 50, 1'b1); do_start(); run_frame(1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    load(1, 0, 1'b1); do_start(); run_frame(1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vertical_edge();
    test_ramp();
    test_backpressure();
    test_reset_midframe();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
